// File: rtl/fetch_queue_if.sv
// Multi-lane fetch queue bus: producer enqueue side, consumer dequeue side,
// flush and status. The queue itself takes the slave modport.
interface fetch_queue_if #(
    parameter int N_LANES = 3,
    parameter int DEPTH   = 8,
    parameter int PKT_W   = 64
);
    localparam int CW = $clog2(N_LANES + 1);
    localparam int OW = $clog2(DEPTH + 1);

    logic [CW-1:0]                   enq_count;
    logic [N_LANES-1:0][PKT_W-1:0]   enq_data;
    logic [CW-1:0]                   free_slots;
    logic [CW-1:0]                   deq_count;
    logic [N_LANES-1:0][PKT_W-1:0]   deq_data;
    logic [CW-1:0]                   deq_valid;
    logic                            flush;
    logic [OW-1:0]                   occupancy;
    logic                            full;
    logic                            empty;
    logic                            ovf_err;
    logic                            udf_err;

    modport master (
        output enq_count, enq_data, deq_count, flush,
        input  free_slots, deq_data, deq_valid, occupancy, full, empty, ovf_err, udf_err
    );

    modport slave (
        input  enq_count, enq_data, deq_count, flush,
        output free_slots, deq_data, deq_valid, occupancy, full, empty, ovf_err, udf_err
    );
endinterface

// File: rtl/fetch_queue.sv
// Multi-lane circular fetch queue: up to N_LANES packets in and out per cycle,
// status derived only from registered state, sticky protocol-violation flags.
module fetch_queue #(
    parameter int N_LANES = 3,
    parameter int DEPTH   = 8,
    parameter int PKT_W   = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_queue_if.slave q
);
    localparam int CW = $clog2(N_LANES + 1);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = PW + 1;

    generate
        if (DEPTH < N_LANES || N_LANES < 1) begin : g_bad_params
            $fatal(1, "fetch_queue: requires N_LANES >= 1 and DEPTH >= N_LANES");
        end
    endgenerate

    logic [PKT_W-1:0]              r_mem [DEPTH];
    logic [PW-1:0]                 r_head;
    logic [PW-1:0]                 r_tail;
    logic [OW-1:0]                 r_occ;
    logic                          r_ovf;
    logic                          r_udf;

    logic [OW-1:0]                 w_room;
    logic [CW-1:0]                 w_free;
    logic [CW-1:0]                 w_dvalid;
    logic [CW-1:0]                 w_acc_enq;
    logic [CW-1:0]                 w_acc_deq;
    logic                          w_enq_ovf;
    logic                          w_deq_udf;
    logic [N_LANES-1:0][PKT_W-1:0] w_deq_data;

    // ptr < DEPTH and off <= DEPTH, so one conditional subtract is a full modulo
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [SW-1:0] off);
        logic [SW-1:0] s;
        s = SW'(ptr) + off;
        if (s >= SW'(DEPTH))
            s = s - SW'(DEPTH);
        return s[PW-1:0];
    endfunction

    always_comb begin
        w_room    = OW'(DEPTH) - r_occ;
        w_free    = (w_room < OW'(N_LANES)) ? CW'(w_room) : CW'(N_LANES);
        w_dvalid  = (r_occ  < OW'(N_LANES)) ? CW'(r_occ)  : CW'(N_LANES);
        w_enq_ovf = q.enq_count > w_free;
        w_deq_udf = q.deq_count > w_dvalid;
        w_acc_enq = w_enq_ovf ? w_free   : q.enq_count;
        w_acc_deq = w_deq_udf ? w_dvalid : q.deq_count;
    end

    always_comb begin
        w_deq_data = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (CW'(i) < w_dvalid)
                w_deq_data[i] = r_mem[wrap_add(r_head, SW'(i))];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (q.flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= wrap_add(r_head, SW'(w_acc_deq));
            r_tail <= wrap_add(r_tail, SW'(w_acc_enq));
            r_occ  <= r_occ + OW'(w_acc_enq) - OW'(w_acc_deq);
            if (w_enq_ovf)
                r_ovf <= 1'b1;
            if (w_deq_udf)
                r_udf <= 1'b1;
        end
    end

    // Storage is unreset; a write landing during reset is unreachable since occupancy restarts at 0
    always_ff @(posedge clock) begin
        if (!q.flush) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                if (CW'(i) < w_acc_enq)
                    r_mem[wrap_add(r_tail, SW'(i))] <= q.enq_data[i];
            end
        end
    end

    assign q.free_slots = w_free;
    assign q.deq_valid  = w_dvalid;
    assign q.deq_data   = w_deq_data;
    assign q.occupancy  = r_occ;
    assign q.full       = (r_occ == OW'(DEPTH));
    assign q.empty      = (r_occ == '0);
    assign q.ovf_err    = r_ovf;
    assign q.udf_err    = r_udf;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue (N_LANES=3, DEPTH=8, PKT_W=64) with
// hand-computed expectations.
module tb_fetch_queue;
    localparam int N  = 3;
    localparam int D  = 8;
    localparam int W  = 64;
    localparam int CW = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    fetch_queue_if #(.N_LANES(N), .DEPTH(D), .PKT_W(W)) q ();

    fetch_queue #(.N_LANES(N), .DEPTH(D), .PKT_W(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (q)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pkt(input int n);
        return 64'hF00D_0000_0000_0000 + 64'(n);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input int cnt, input int base);
        q.enq_count = CW'(cnt);
        for (int i = 0; i < N; i++)
            q.enq_data[i] = (i < cnt) ? pkt(base + i) : '0;
    endtask

    task automatic check_idle_empty(input string tag);
        check({tag, "_occ"},   64'(q.occupancy), 64'd0);
        check({tag, "_empty"}, 64'(q.empty),     64'd1);
        check({tag, "_dv"},    64'(q.deq_valid), 64'd0);
        check({tag, "_data"},  64'(q.deq_data == '0), 64'd1);
    endtask

    initial begin
        q.enq_count = '0;
        q.enq_data  = '0;
        q.deq_count = '0;
        q.flush     = 1'b0;

        #2;
        check_idle_empty("rst");
        check("rst_full", 64'(q.full),       64'd0);
        check("rst_free", 64'(q.free_slots), 64'd3);
        check("rst_ovf",  64'(q.ovf_err),    64'd0);
        check("rst_udf",  64'(q.udf_err),    64'd0);

        // Fill 3,3,2 to full; first edge after deassertion accepts
        #6 reset_n = 1'b1;
        offer(3, 0);
        step();
        check("fill1_occ",  64'(q.occupancy), 64'd3);
        check("fill1_l0",   q.deq_data[0],    pkt(0));
        offer(3, 3);
        step();
        check("fill2_free", 64'(q.free_slots), 64'd2);
        offer(2, 6);
        step();
        offer(0, 0);
        check("fill3_occ",  64'(q.occupancy),  64'd8);
        check("fill3_full", 64'(q.full),       64'd1);
        check("fill3_free", 64'(q.free_slots), 64'd0);
        check("fill3_l0",   q.deq_data[0],     pkt(0));
        check("fill3_l1",   q.deq_data[1],     pkt(1));
        check("fill3_l2",   q.deq_data[2],     pkt(2));
        check("fill3_ovf",  64'(q.ovf_err),    64'd0);

        // Flush while full with an overflowing offer: no flag may rise
        offer(3, 20);
        q.deq_count = 2'd3;
        q.flush = 1'b1;
        step();
        q.flush = 1'b0;
        q.deq_count = 2'd0;
        offer(1, 30);
        check_idle_empty("flush1");
        check("flush1_ovf", 64'(q.ovf_err), 64'd0);
        check("flush1_udf", 64'(q.udf_err), 64'd0);
        step();
        offer(0, 0);
        check("postflush_l0", q.deq_data[0],    pkt(30));
        check("postflush_dv", 64'(q.deq_valid), 64'd1);

        // Underflow: occupancy 1, ask for 2
        q.deq_count = 2'd2;
        step();
        q.deq_count = 2'd0;
        check("udf_empty", 64'(q.empty),   64'd1);
        check("udf_flag",  64'(q.udf_err), 64'd1);
        repeat (10) step();
        check("udf_sticky", 64'(q.udf_err), 64'd1);

        // head=tail=1: fill, then dequeue 3 while offering 3 at full
        offer(3, 40); step();
        offer(3, 43); step();
        offer(2, 46); step();
        check("fill_b_full", 64'(q.full), 64'd1);
        offer(3, 50);
        q.deq_count = 2'd3;
        step();
        q.deq_count = 2'd0;
        offer(0, 0);
        check("fulldeq_occ", 64'(q.occupancy),  64'd5);
        check("fulldeq_ovf", 64'(q.ovf_err),    64'd1);
        check("fulldeq_l0",  q.deq_data[0],     pkt(43));
        check("fulldeq_l2",  q.deq_data[2],     pkt(45));
        check("fulldeq_free", 64'(q.free_slots), 64'd3);

        // Flush at occupancy 5 with enq_count=3
        offer(3, 60);
        q.flush = 1'b1;
        step();
        q.flush = 1'b0;
        offer(1, 70);
        check_idle_empty("flush2");
        step();
        check("flush2_next_l0", q.deq_data[0], pkt(70));
        offer(3, 71);
        step();
        check("pre_rst_occ", 64'(q.occupancy), 64'd4);

        // Asynchronous reset between edges with an enqueue offered
        offer(3, 80);
        #3 reset_n = 1'b0;
        #1;
        check_idle_empty("arst");
        check("arst_free", 64'(q.free_slots), 64'd3);
        check("arst_ovf",  64'(q.ovf_err),    64'd0);
        check("arst_udf",  64'(q.udf_err),    64'd0);
        step();
        #2;
        offer(0, 0);
        reset_n = 1'b1;
        step();
        check_idle_empty("arst_after");

        // Move head=tail=7, then enqueue across the wrap
        offer(3, 100); step();
        offer(3, 103); step();
        offer(1, 106); step();
        offer(0, 0);
        check("wrap_fill_occ", 64'(q.occupancy), 64'd7);
        q.deq_count = 2'd3; step();
        step();
        q.deq_count = 2'd1; step();
        q.deq_count = 2'd0;
        check("wrap_drain_empty", 64'(q.empty), 64'd1);
        offer(3, 110);
        step();
        offer(0, 0);
        check("wrap_l0",  q.deq_data[0],    pkt(110));
        check("wrap_l1",  q.deq_data[1],    pkt(111));
        check("wrap_l2",  q.deq_data[2],    pkt(112));
        check("wrap_occ", 64'(q.occupancy), 64'd3);
        q.deq_count = 2'd3;
        step();
        q.deq_count = 2'd0;
        check("wrap_out_empty", 64'(q.empty), 64'd1);

        // Enqueue and over-dequeue together while empty: acc_deq is 0
        offer(2, 120);
        q.deq_count = 2'd3;
        step();
        offer(0, 0);
        q.deq_count = 2'd0;
        check("simul_occ", 64'(q.occupancy), 64'd2);
        check("simul_dv",  64'(q.deq_valid), 64'd2);
        check("simul_l0",  q.deq_data[0],    pkt(120));
        check("simul_l1",  q.deq_data[1],    pkt(121));
        check("simul_l2",  q.deq_data[2],    64'd0);
        check("simul_udf", 64'(q.udf_err),   64'd1);
        check("simul_ovf", 64'(q.ovf_err),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
